// File: rtl/bmem_responder.sv
// bmem_responder: 256-bit line backing store that answers line-read requests
// with four 64-bit beats after a fixed latency and accepts four-beat line
// writes. Reads are queued with their acceptance time and returned in order.
// Optional build macro BMEM_RESPONDER_CHECK_EN adds a sticky bmem_err output.
//
// Read burst FSM
//   state   | meaning
//   RD_IDLE | no burst on the return bus
//   RD_B0   | beat 0 (line[63:0]) on bmem_rdata
//   RD_B1   | beat 1
//   RD_B2   | beat 2
//   RD_B3   | beat 3; head entry pops at the end of this cycle
//
// Write burst FSM
//   state   | meaning
//   WR_IDLE | no write burst, next write beat with ready is beat 0
//   WR_B1   | waiting for write beat 1
//   WR_B2   | waiting for write beat 2
//   WR_B3   | waiting for write beat 3 (line commits on that beat)
module bmem_responder #(
  parameter int LINES   = 64,
  parameter int LATENCY = 4,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid
`ifdef BMEM_RESPONDER_CHECK_EN
  ,
  output logic        bmem_err
`endif
);

  localparam int          IW    = $clog2(LINES);
  localparam int          QW    = $clog2(QDEPTH);
  localparam logic [QW:0] QFULL = (QW+1)'(QDEPTH);
  localparam logic [31:0] LAT32 = 32'(LATENCY);

  typedef enum logic [2:0] {RD_IDLE, RD_B0, RD_B1, RD_B2, RD_B3} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_B1, WR_B2, WR_B3} wr_state_t;

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic [255:0]  mem [LINES];

  // Pending-read queue: the head entry stays resident while its burst plays
  // out, so a full queue only frees a slot when a burst finishes.
  logic [31:0]   q_addr [QDEPTH];
  logic [31:0]   q_due  [QDEPTH];
  logic [QW-1:0] q_rd;
  logic [QW-1:0] q_wr;
  logic [QW:0]   q_cnt;
  logic [31:0]   cyc;

  logic [IW-1:0] wr_idx;
  logic [63:0]   wbuf [3];

  logic [255:0]  line_q;
  logic [31:0]   raddr_q;

  logic          q_full;
  logic          wr_idle;
  logic          rd_accept;
  logic          wr_start;
  logic          wr_beat;
  logic          wr_commit;
  logic          burst_busy;
  logic          burst_last;
  logic          burst_start;
  logic [QW-1:0] cand_slot;
  logic          cand_avail;
  logic [31:0]   due_diff;
  logic          due_reached;
  logic [IW-1:0] cand_idx;
  logic [255:0]  wr_line;
  logic [255:0]  fill_line;

  assign q_full     = (q_cnt == QFULL);
  assign wr_idle    = (wr_state == WR_IDLE);
  assign bmem_ready = !rst && !q_full && wr_idle;
  assign rd_accept  = bmem_read && bmem_ready && !bmem_write;
  assign wr_start   = bmem_write && bmem_ready;
  assign wr_beat    = bmem_write && !wr_idle;
  assign wr_commit  = wr_beat && (wr_state == WR_B3);

  assign burst_busy = (rd_state != RD_IDLE);
  assign burst_last = (rd_state == RD_B3);

  // While a burst is active the head is that burst, so the next candidate is
  // the entry behind it; this lets bursts run back to back.
  assign cand_slot  = burst_busy ? q_rd + QW'(1) : q_rd;
  assign cand_avail = burst_busy ? (q_cnt >= (QW+1)'(2)) : (q_cnt != '0);

  // Starting now puts the first beat in the next cycle, hence cyc + 1.
  // Wrap-safe compare on the difference.
  assign due_diff    = cyc + 32'd1 - q_due[cand_slot];
  assign due_reached = !due_diff[31];

  assign cand_idx = q_addr[cand_slot][5 +: IW];
  assign wr_line  = {bmem_wdata, wbuf[2], wbuf[1], wbuf[0]};

  // A write committing on the same edge the line is latched must be seen by
  // the read, whose first beat follows the commit cycle.
  assign fill_line = (wr_commit && (wr_idx == cand_idx)) ? wr_line : mem[cand_idx];

  // Read burst next-state: advance beats, chain straight into a due burst.
  always_comb begin
    rd_next     = rd_state;
    burst_start = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (cand_avail && due_reached) begin
          burst_start = 1'b1;
          rd_next     = RD_B0;
        end
      end
      RD_B0: rd_next = RD_B1;
      RD_B1: rd_next = RD_B2;
      RD_B2: rd_next = RD_B3;
      RD_B3: begin
        if (cand_avail && due_reached) begin
          burst_start = 1'b1;
          rd_next     = RD_B0;
        end else begin
          rd_next = RD_IDLE;
        end
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  // Return-bus outputs decoded from the burst state; zero outside a burst.
  always_comb begin
    bmem_rvalid = burst_busy;
    bmem_raddr  = 32'd0;
    bmem_rdata  = 64'd0;
    case (rd_state)
      RD_B0:   bmem_rdata = line_q[63:0];
      RD_B1:   bmem_rdata = line_q[127:64];
      RD_B2:   bmem_rdata = line_q[191:128];
      RD_B3:   bmem_rdata = line_q[255:192];
      default: bmem_rdata = 64'd0;
    endcase
    if (burst_busy) begin
      bmem_raddr = raddr_q;
    end
  end

  // Write burst next-state: a low bmem_write mid-burst simply waits.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (wr_start)   wr_next = WR_B1;
      WR_B1:   if (bmem_write) wr_next = WR_B2;
      WR_B2:   if (bmem_write) wr_next = WR_B3;
      WR_B3:   if (bmem_write) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  // FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      wr_state <= WR_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  // Pending-read queue and the free-running cycle stamp.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
      cyc   <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_due[i] <= '0;
      end
    end else begin
      cyc <= cyc + 32'd1;
      if (rd_accept) begin
        q_addr[q_wr] <= bmem_addr;
        q_due[q_wr]  <= cyc + LAT32;
        q_wr         <= q_wr + QW'(1);
      end
      if (burst_last) begin
        q_rd <= q_rd + QW'(1);
      end
      q_cnt <= q_cnt + (QW+1)'(rd_accept) - (QW+1)'(burst_last);
    end
  end

  // Snapshot the whole line and its address when a burst starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q  <= '0;
      raddr_q <= '0;
    end else if (burst_start) begin
      line_q  <= fill_line;
      raddr_q <= q_addr[cand_slot];
    end
  end

  // Collect write beats 0..2; beat 3 goes straight into the commit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_start) begin
        wr_idx  <= bmem_addr[5 +: IW];
        wbuf[0] <= bmem_wdata;
      end
      if (wr_beat && (wr_state == WR_B1)) begin
        wbuf[1] <= bmem_wdata;
      end
      if (wr_beat && (wr_state == WR_B2)) begin
        wbuf[2] <= bmem_wdata;
      end
    end
  end

  // Backing store: kept across reset, updated only by a completed write.
  always_ff @(posedge clk) begin
    if (!rst && wr_commit) begin
      mem[wr_idx] <= wr_line;
    end
  end

`ifdef BMEM_RESPONDER_CHECK_EN
  logic err_event;

  assign err_event = ((rd_accept || wr_start) && (bmem_addr[4:0] != 5'd0)) ||
                     (bmem_read && bmem_write && bmem_ready);

  // Sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      bmem_err <= 1'b0;
    end else if (err_event) begin
      bmem_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bmem_responder.sv
// Testbench for bmem_responder: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a transaction-level
// model (bursts scheduled by arithmetic on acceptance times).
module tb_bmem_responder;

  localparam int LINES  = 64;
  localparam int LAT    = 4;
  localparam int QDEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bmem_addr = '0;
  logic        bmem_read = 1'b0;
  logic        bmem_write = 1'b0;
  logic [63:0] bmem_wdata = '0;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
`ifdef BMEM_RESPONDER_CHECK_EN
  logic        bmem_err;
`endif

  bmem_responder #(.LINES(LINES), .LATENCY(LAT), .QDEPTH(QDEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
`ifdef BMEM_RESPONDER_CHECK_EN
    , .bmem_err (bmem_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  typedef struct {
    logic [31:0] addr;
    int          start;
  } ent_t;

  ent_t         mq[$];
  int           c = 0;
  int           last_end = -100;
  logic [255:0] mm [LINES];
  bit           mv [LINES];
  logic [255:0] cur_line = '0;
  bit           cur_v = 1'b0;
  bit           wact = 1'b0;
  int           wbeat = 0;
  int           widx = 0;
  logic [63:0]  wb [4];

  logic         s_ready, s_rvalid;
  logic [31:0]  s_raddr;
  logic [63:0]  s_rdata;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 5) & 32'(LINES - 1));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, c, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance
  // the model by the inputs, then cross the clock edge.
  task automatic mstep(input logic r, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [63:0] wd);
    logic        e_ready, e_rv;
    logic [31:0] e_ra;
    logic [63:0] e_rd;
    int          k, st;
    rst = r; bmem_read = rd; bmem_write = wr; bmem_addr = a; bmem_wdata = wd;
    #1;
    while (mq.size() > 0 && mq[0].start + 3 < c) void'(mq.pop_front());
    e_ready = !r && (mq.size() < QDEPTH) && !wact;
    e_rv = 1'b0; e_ra = '0; e_rd = '0;
    if (mq.size() > 0 && mq[0].start <= c) begin
      if (mq[0].start == c) begin
        cur_line = mm[idx_of(mq[0].addr)];
        cur_v    = mv[idx_of(mq[0].addr)];
      end
      k    = c - mq[0].start;
      e_rv = 1'b1;
      e_ra = mq[0].addr;
      e_rd = cur_line[64*k +: 64];
    end
    s_ready = bmem_ready; s_rvalid = bmem_rvalid; s_raddr = bmem_raddr; s_rdata = bmem_rdata;
    chk("ready", {63'd0, s_ready}, {63'd0, e_ready});
    chk("rvalid", {63'd0, s_rvalid}, {63'd0, e_rv});
    chk("raddr", {32'd0, s_raddr}, {32'd0, e_ra});
    if (!e_rv || cur_v) chk("rdata", s_rdata, e_rd);
    if (r) begin
      mq.delete();
      wact = 1'b0;
      last_end = c - 100;
    end else begin
      if (wr && !wact && e_ready) begin
        wact = 1'b1; wbeat = 1; widx = idx_of(a); wb[0] = wd;
      end else if (wr && wact) begin
        wb[wbeat] = wd;
        if (wbeat == 3) begin
          mm[widx] = {wd, wb[2], wb[1], wb[0]};
          mv[widx] = 1'b1;
          wact = 1'b0;
        end else begin
          wbeat++;
        end
      end
      if (rd && !wr && e_ready) begin
        st = (c + LAT > last_end + 1) ? c + LAT : last_end + 1;
        mq.push_back('{addr: a, start: st});
        last_end = st + 3;
      end
    end
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) mstep(1'b0, 1'b0, 1'b0, 32'd0, 64'd0);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wd;
    logic        e_ready;
    logic        e_rv;
    logic [31:0] e_ra;
    logic [63:0] e_rd;
  } vec_t;

  localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] D4 = 64'h4444_4444_4444_4444;

  vec_t tv [13];

  initial begin
    int          cnt;
    logic [31:0] ra [4];
    logic [31:0] iss [4];
    logic [63:0] nd [4];

    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;

    // Write line 0x40, read it back: beats 4..7 cycles after the read.
    tv[0]  = '{1'b0, 1'b1, 32'h40, D1,    1'b1, 1'b0, 32'h0,  64'h0};
    tv[1]  = '{1'b0, 1'b1, 32'h40, D2,    1'b0, 1'b0, 32'h0,  64'h0};
    tv[2]  = '{1'b0, 1'b1, 32'h40, D3,    1'b0, 1'b0, 32'h0,  64'h0};
    tv[3]  = '{1'b0, 1'b1, 32'h40, D4,    1'b0, 1'b0, 32'h0,  64'h0};
    tv[4]  = '{1'b1, 1'b0, 32'h40, 64'h0, 1'b1, 1'b0, 32'h0,  64'h0};
    tv[5]  = '{1'b0, 1'b0, 32'h0,  64'h0, 1'b1, 1'b0, 32'h0,  64'h0};
    tv[6]  = '{1'b0, 1'b0, 32'h0,  64'h0, 1'b1, 1'b0, 32'h0,  64'h0};
    tv[7]  = '{1'b0, 1'b0, 32'h0,  64'h0, 1'b1, 1'b0, 32'h0,  64'h0};
    tv[8]  = '{1'b0, 1'b0, 32'h0,  64'h0, 1'b1, 1'b1, 32'h40, D1};
    tv[9]  = '{1'b0, 1'b0, 32'h0,  64'h0, 1'b1, 1'b1, 32'h40, D2};
    tv[10] = '{1'b0, 1'b0, 32'h0,  64'h0, 1'b1, 1'b1, 32'h40, D3};
    tv[11] = '{1'b0, 1'b0, 32'h0,  64'h0, 1'b1, 1'b1, 32'h40, D4};
    tv[12] = '{1'b0, 1'b0, 32'h0,  64'h0, 1'b1, 1'b0, 32'h0,  64'h0};

    @(posedge clk);
    #1;
    mstep(1'b1, 1'b0, 1'b0, 32'd0, 64'd0);
    mstep(1'b1, 1'b0, 1'b0, 32'd0, 64'd0);
    chk("reset_ready", {63'd0, s_ready}, 64'd0);
    chk("reset_rvalid", {63'd0, s_rvalid}, 64'd0);

    for (int i = 0; i < 13; i++) begin
      mstep(1'b0, tv[i].rd, tv[i].wr, tv[i].addr, tv[i].wd);
      chk($sformatf("vec%0d_ready", i), {63'd0, s_ready}, {63'd0, tv[i].e_ready});
      chk($sformatf("vec%0d_rvalid", i), {63'd0, s_rvalid}, {63'd0, tv[i].e_rv});
      chk($sformatf("vec%0d_raddr", i), {32'd0, s_raddr}, {32'd0, tv[i].e_ra});
      chk($sformatf("vec%0d_rdata", i), s_rdata, tv[i].e_rd);
    end

    // Write 0x100 with a two-cycle gap after beat 0; ready stays low.
    mstep(1'b0, 1'b0, 1'b1, 32'h100, 64'hA1);
    mstep(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("gap_ready0", {63'd0, s_ready}, 64'd0);
    mstep(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("gap_ready1", {63'd0, s_ready}, 64'd0);
    mstep(1'b0, 1'b0, 1'b1, 32'h0, 64'hA2);
    mstep(1'b0, 1'b0, 1'b1, 32'h0, 64'hA3);
    mstep(1'b0, 1'b0, 1'b1, 32'h0, 64'hA4);
    chk("gap_ready3", {63'd0, s_ready}, 64'd0);
    mstep(1'b0, 1'b1, 1'b0, 32'h100, 64'h0);
    chk("gap_ready_after", {63'd0, s_ready}, 64'd1);
    idle(3);
    mstep(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("gap_beat0", s_rdata, 64'hA1);
    mstep(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    mstep(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    mstep(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("gap_beat3", s_rdata, 64'hA4);
    idle(4);

    // Four back-to-back reads: 16 contiguous beats, ready low while full.
    iss[0] = 32'h40; iss[1] = 32'h100; iss[2] = 32'h840; iss[3] = 32'h100;
    for (int i = 0; i < 4; i++) mstep(1'b0, 1'b1, 1'b0, iss[i], 64'h0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      mstep(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
      if (i == 0) chk("b2b_ready_full", {63'd0, s_ready}, 64'd0);
      if (i == 4) chk("b2b_ready_freed", {63'd0, s_ready}, 64'd1);
      if (i < 16 && (i % 4) == 0) ra[i/4] = s_raddr;
      if (s_rvalid) cnt++;
    end
    chk("b2b_beat_count", 64'(cnt), 64'd16);
    for (int i = 0; i < 4; i++) chk($sformatf("b2b_order%0d", i), {32'd0, ra[i]}, {32'd0, iss[i]});

    // Read and write together at 0x80: write wins, no read burst.
    mstep(1'b0, 1'b1, 1'b1, 32'h80, 64'hB1);
    mstep(1'b0, 1'b0, 1'b1, 32'h80, 64'hB2);
    chk("coll_write_taken", {63'd0, s_ready}, 64'd0);
    mstep(1'b0, 1'b0, 1'b1, 32'h80, 64'hB3);
    mstep(1'b0, 1'b0, 1'b1, 32'h80, 64'hB4);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      mstep(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
      if (s_rvalid) cnt++;
    end
    chk("coll_no_burst", 64'(cnt), 64'd0);

    // Reset during beat 2 of a burst.
    mstep(1'b0, 1'b1, 1'b0, 32'h40, 64'h0);
    idle(5);
    mstep(1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("rst_mid_beat2", s_rdata, D3);
    mstep(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("rst_rvalid_low", {63'd0, s_rvalid}, 64'd0);
    chk("rst_ready_high", {63'd0, s_ready}, 64'd1);
    idle(8);
    chk("rst_queue_empty", {63'd0, s_rvalid}, 64'd0);

    // Read 0x40 queued behind 0x80; a write to 0x40 commits the cycle before
    // its first beat and the burst must carry the new line.
    nd[0] = 64'hC0C0_0000_0000_0001; nd[1] = 64'hC0C0_0000_0000_0002;
    nd[2] = 64'hC0C0_0000_0000_0003; nd[3] = 64'hC0C0_0000_0000_0004;
    mstep(1'b0, 1'b1, 1'b0, 32'h80, 64'h0);
    mstep(1'b0, 1'b1, 1'b0, 32'h40, 64'h0);
    idle(2);
    for (int i = 0; i < 4; i++) mstep(1'b0, 1'b0, 1'b1, 32'h40, nd[i]);
    for (int i = 0; i < 4; i++) begin
      mstep(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
      chk($sformatf("fwd_raddr%0d", i), {32'd0, s_raddr}, 64'h40);
      chk($sformatf("fwd_beat%0d", i), s_rdata, nd[i]);
    end
    idle(4);

    // Preload lines 0..7, then randomized traffic against the model.
    for (int l = 0; l < 8; l++)
      for (int b = 0; b < 4; b++)
        mstep(1'b0, 1'b0, 1'b1, 32'(l) << 5, {$urandom, $urandom});
    for (int i = 0; i < 1500; i++) begin
      logic        r, rd, wr;
      logic [31:0] a;
      r  = ($urandom_range(0, 199) == 0);
      rd = ($urandom_range(0, 99) < 45);
      wr = ($urandom_range(0, 99) < (wact ? 70 : 12));
      a  = ($urandom & 32'hFFFF_F800) | (32'($urandom_range(0, 7)) << 5);
      mstep(r, rd, wr, a, {$urandom, $urandom});
    end
    idle(24);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
